// File: rtl/comm_slave.sv
// comm_slave: copter-side UART endpoint. Assembles 3-byte command frames
// (cmd, data_hi, data_lo) from RX and serializes a one-byte response on TX.
module comm_slave #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_XMIT = 1'b1
  } tx_state_t;

  // ---------------------------------------------------------------- RX side
  logic             rx_meta, rx_sync, rx_prev;
  logic             rx_fall;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt;
  logic             rx_tick;
  logic [2:0]       rx_bit_idx;
  logic [7:0]       rx_shift;
  logic             rx_load, rx_start_ok, rx_shift_en, rx_byte_ok, rx_byte_bad;

  logic [1:0]       byte_idx;
  logic [7:0]       cmd_shadow;
  logic [7:0]       hi_shadow;
  logic             frame_done;

  // Two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_tick = (rx_state != RX_IDLE) && (rx_cnt == CNT_ONE);

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  // RX next-state logic
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
      RX_START: if (rx_tick) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit_idx == 3'd7)) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX control strobes decoded from the current state
  always_comb begin
    rx_load     = 1'b0;
    rx_start_ok = 1'b0;
    rx_shift_en = 1'b0;
    rx_byte_ok  = 1'b0;
    rx_byte_bad = 1'b0;
    case (rx_state)
      RX_IDLE:  rx_load     = rx_fall;
      RX_START: rx_start_ok = rx_tick & ~rx_sync;
      RX_DATA:  rx_shift_en = rx_tick;
      RX_STOP: begin
        rx_byte_ok  = rx_tick & rx_sync;
        rx_byte_bad = rx_tick & ~rx_sync;
      end
      default: ;
    endcase
  end

  // Bit timing counter and LSB-first data shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
    end else begin
      if (rx_load)                    rx_cnt <= BAUD_HALF;
      else if (rx_tick)               rx_cnt <= BAUD_FULL;
      else if (rx_state != RX_IDLE)   rx_cnt <= rx_cnt - CNT_ONE;

      if (rx_start_ok)                rx_bit_idx <= '0;
      else if (rx_shift_en)           rx_bit_idx <= rx_bit_idx + 3'd1;

      if (rx_shift_en)                rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  assign frame_done = rx_byte_ok && (byte_idx == 2'd2);

  // Frame assembly; outputs only move when the third byte lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      cmd_shadow <= '0;
      hi_shadow  <= '0;
      cmd        <= '0;
      data       <= '0;
      frm_err    <= 1'b0;
    end else begin
      frm_err <= rx_byte_bad;
      if (rx_byte_bad) begin
        byte_idx <= '0;
      end else if (rx_byte_ok) begin
        case (byte_idx)
          2'd0: begin
            cmd_shadow <= rx_shift;
            byte_idx   <= 2'd1;
          end
          2'd1: begin
            hi_shadow <= rx_shift;
            byte_idx  <= 2'd2;
          end
          2'd2: begin
            cmd      <= cmd_shadow;
            data     <= {hi_shadow, rx_shift};
            byte_idx <= 2'd0;
          end
          default: byte_idx <= 2'd0;
        endcase
      end
    end
  end

  // Sticky frame-ready flag; a confirmed start of a new frame also clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          cmd_rdy <= 1'b0;
    else if (frame_done)                                 cmd_rdy <= 1'b1;
    else if (clr_cmd_rdy || (rx_start_ok && (byte_idx == 2'd0))) cmd_rdy <= 1'b0;
  end

  // ---------------------------------------------------------------- TX side
  tx_state_t        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit_idx;
  logic [9:0]       tx_shift;
  logic             tx_tick;
  logic             tx_load, tx_shift_en, tx_done;

  assign tx_tick = (tx_state == TX_XMIT) && (tx_cnt == CNT_ONE);

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  // TX next-state logic
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (send_resp) tx_state_nxt = TX_XMIT;
      TX_XMIT: if (tx_tick && (tx_bit_idx == 4'd9)) tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX control strobes; send_resp is only honoured while idle
  always_comb begin
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    tx_done     = 1'b0;
    case (tx_state)
      TX_IDLE: tx_load = send_resp;
      TX_XMIT: begin
        tx_shift_en = tx_tick;
        tx_done     = tx_tick && (tx_bit_idx == 4'd9);
      end
      default: ;
    endcase
  end

  // Shift register, bit timer and completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift   <= '1;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
      resp_sent  <= 1'b0;
    end else if (tx_load) begin
      tx_shift   <= {1'b1, resp, 1'b0};
      tx_cnt     <= BAUD_FULL;
      tx_bit_idx <= '0;
      resp_sent  <= 1'b0;
    end else if (tx_shift_en) begin
      tx_shift   <= {1'b1, tx_shift[9:1]};
      tx_cnt     <= BAUD_FULL;
      tx_bit_idx <= tx_bit_idx + 4'd1;
      if (tx_done) resp_sent <= 1'b1;
    end else if (tx_state == TX_XMIT) begin
      tx_cnt <= tx_cnt - CNT_ONE;
    end
  end

  assign TX = tx_shift[0];

endmodule

// File: tb/tb_comm_slave.sv
// Scoreboard bench for comm_slave: stimulus pushes expected frames/responses,
// independent monitors pop and compare when the DUT presents them.
module tb_comm_slave;

  localparam int unsigned BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        frm_err;

  comm_slave #(.BAUD_DIV(BAUD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
    logic [31:0] t;
  } frame_t;

  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] t;
  } tx_t;

  frame_t exp_q[$];
  tx_t    tx_q[$];

  // Reference model of frame assembly: byte position and pending bytes
  int         midx = 0;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_hi  = 8'h00;
  int         exp_frm = 0;
  int         tx_exp_done = 0;
  bit         abort_rx = 1'b0;

  int tx_done_cnt = 0;
  int sent_rises  = 0;
  int frm_rises   = 0;
  int frm_cycles  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event got 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_TX",        32'(TX),        32'h1);
    check("rst_cmd",       32'(cmd),       32'h0);
    check("rst_data",      32'(data),      32'h0);
    check("rst_cmd_rdy",   32'(cmd_rdy),   32'h0);
    check("rst_resp_sent", 32'(resp_sent), 32'h0);
    check("rst_frm_err",   32'(frm_err),   32'h0);
  endtask

  // One UART byte on RX; the model is updated before driving so the
  // expectation is queued ahead of the DUT's response
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0]  fr;
    int unsigned a;
    frame_t      f;
    fr = {stop_ok, b, 1'b0};
    tick();
    a = cyc;
    if (!stop_ok) begin
      exp_frm++;
      midx = 0;
    end else if (midx == 0) begin
      m_cmd = b;
      midx  = 1;
    end else if (midx == 1) begin
      m_hi = b;
      midx = 2;
    end else begin
      f.c = m_cmd;
      f.d = {m_hi, b};
      f.t = a + 32'd155;
      exp_q.push_back(f);
      midx = 0;
    end
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      for (int j = 0; j < int'(BAUD); j++) begin
        if (abort_rx) begin
          RX = 1'b1;
          return;
        end
        tick();
      end
    end
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(c, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
  endtask

  task automatic glitch();
    tick();
    RX = 1'b0;
    repeat (4) tick();
    RX = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] r, input bit resend);
    int unsigned e0;
    tx_t t;
    tick();
    e0 = cyc;
    resp = r;
    send_resp = 1'b1;
    t.b = r;
    t.t = e0;
    tx_q.push_back(t);
    tx_exp_done++;
    tick();
    send_resp = 1'b0;
    if (resend) begin
      while (cyc < e0 + 32'd50) tick();
      resp = 8'hFF;
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
    end
    while (cyc < e0 + 32'd165) tick();
  endtask

  // Frame monitor: every cmd_rdy rise must match the next queued frame
  initial begin : cmd_mon
    logic        prev_rdy;
    logic [7:0]  prev_cmd;
    logic [15:0] prev_data;
    frame_t      f;
    prev_rdy  = 1'b0;
    prev_cmd  = 8'h00;
    prev_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy = 1'b0;
      end else if (cmd_rdy && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          fail_evt("cmd_unexpected");
        end else begin
          f = exp_q.pop_front();
          check("cmd_value", 32'(cmd),  32'(f.c));
          check("data_value", 32'(data), 32'(f.d));
          check("cmd_rdy_time", cyc, f.t);
        end
      end else if ((cmd !== prev_cmd) || (data !== prev_data)) begin
        fail_evt("cmd_data_disturbed");
      end
      prev_rdy  = cmd_rdy;
      prev_cmd  = cmd;
      prev_data = data;
    end
  end

  // TX monitor: each start bit must match the next queued response,
  // with every bit held exactly BAUD clocks and resp_sent rising on time
  initial begin : tx_mon
    logic       prev_tx;
    tx_t        t;
    logic [9:0] exp_fr;
    logic [9:0] got;
    bit         hold_ok;
    bit         aborted;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev_tx && !TX) begin
        if (tx_q.size() == 0) begin
          fail_evt("tx_unexpected");
        end else begin
          t = tx_q.pop_front();
          check("tx_start_time", cyc, t.t + 32'd1);
          exp_fr  = {1'b1, t.b, 1'b0};
          got     = '0;
          hold_ok = 1'b1;
          aborted = 1'b0;
          for (int j = 0; j < 10 * int'(BAUD); j++) begin
            if (j > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (TX !== exp_fr[j / int'(BAUD)]) hold_ok = 1'b0;
            if (resp_sent !== 1'b0) hold_ok = 1'b0;
            if ((j % int'(BAUD)) == int'(BAUD / 2)) got[j / int'(BAUD)] = TX;
          end
          if (!aborted) begin
            check("tx_waveform", 32'(hold_ok), 32'h1);
            check("tx_frame", 32'(got), 32'(exp_fr));
            @(negedge clk);
            check("resp_sent_161", 32'(resp_sent), 32'h1);
            check("tx_idle_high", 32'(TX), 32'h1);
            tx_done_cnt++;
          end
        end
      end
      prev_tx = TX;
    end
  end

  // Event counters for resp_sent rises and frm_err pulses
  initial begin : evt_mon
    logic prev_rs;
    logic prev_fe;
    prev_rs = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (resp_sent && !prev_rs) sent_rises++;
        if (frm_err && !prev_fe)   frm_rises++;
        if (frm_err)               frm_cycles++;
      end
      prev_rs = resp_sent;
      prev_fe = frm_err;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [7:0] bb [3];
    int         bad_pos;

    rst_n       = 1'b0;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    resp        = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Basic frame and clear
    send_frame(8'h05, 8'h01, 8'hFF);
    check("cmd_rdy_before_clr", 32'(cmd_rdy), 32'h1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("cmd_rdy_after_clr", 32'(cmd_rdy), 32'h0);

    // Command then response
    send_frame(8'h06, 8'h00, 8'h00);
    send_tx(8'hA5, 1'b0);

    // Bad stop bit in byte 2, then a clean frame
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (10) tick();
    check("cmd_held_after_err", 32'(cmd), 32'h06);
    check("data_held_after_err", 32'(data), 32'h0000);
    send_frame(8'h02, 8'h12, 8'h34);

    // Short low glitch on idle RX
    repeat (10) tick();
    glitch();
    repeat (30) tick();
    check("no_err_on_glitch", 32'(frm_err), 32'h0);
    send_frame(8'h03, 8'hAB, 8'hCD);

    // Second send_resp while busy must be ignored
    send_tx(8'h5A, 1'b1);

    // Reset in the middle of RX byte 2 and an in-flight TX
    fork
      begin
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
      end
      begin
        repeat (150) tick();
        send_tx(8'hC3, 1'b0);
      end
      begin
        repeat (220) tick();
        abort_rx = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        tick();
        tick();
        midx = 0;
        exp_q.delete();
        tx_q.delete();
        tx_exp_done--;
        rst_n = 1'b1;
        abort_rx = 1'b0;
      end
    join
    repeat (20) tick();
    send_frame(8'h09, 8'hBE, 8'hEF);
    send_tx(8'h3C, 1'b0);

    // Randomized concurrent RX frames, TX responses and clears
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          repeat ($urandom_range(0, 30)) tick();
          if ($urandom_range(0, 3) == 0) begin
            glitch();
            repeat (20) tick();
          end
          for (int k = 0; k < 3; k++) bb[k] = 8'($urandom);
          bad_pos = int'($urandom_range(0, 5));
          for (int k = 0; k < 3; k++) send_byte(bb[k], k != bad_pos);
        end
      end
      begin
        for (int n = 0; n < 6; n++) begin
          repeat ($urandom_range(5, 200)) tick();
          send_tx(8'($urandom), $urandom_range(0, 2) == 0);
        end
      end
      begin
        for (int n = 0; n < 15; n++) begin
          repeat ($urandom_range(20, 200)) tick();
          clr_cmd_rdy = 1'b1;
          tick();
          clr_cmd_rdy = 1'b0;
        end
      end
    join

    repeat (300) tick();
    check("cmd_queue_drained", 32'(exp_q.size()), 32'h0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
    check("tx_frames_done", 32'(tx_done_cnt), 32'(tx_exp_done));
    check("resp_sent_rises", 32'(sent_rises), 32'(tx_exp_done));
    check("frm_err_pulses", 32'(frm_rises), 32'(exp_frm));
    check("frm_err_cycles", 32'(frm_cycles), 32'(exp_frm));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
